// File: rtl/sirv_uart_pkg.sv
// sirv_uart_pkg
// Shared definitions for the UART blocks: transmit FSM state encoding,
// data-bit count and frame-length constants.
// Optional feature macro: SIRV_UART_TXARB_PARITY_EN (adds an even-parity bit).
package sirv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int         UART_DATA_BITS = 8;
    // Bit-counter value of the final data bit (MSB).
    localparam logic [2:0] UART_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    // Bit periods per frame: start + data + [parity] + stop.
    localparam int UART_FRAME_BITS_8N1 = 10;
    localparam int UART_FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/sirv_uart_baudtick.sv
// sirv_uart_baudtick
// Loadable baud-rate down-counter. Loading with div makes the counter hold
// each bit for div+1 clocks; tick is high while the count is zero.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   load         : load div into the counter this cycle
//   div          : reload value (bit period minus one)
//   tick         : count has reached zero (last clock of the bit period)
module sirv_uart_baudtick #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= div;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/sirv_uart_txarb.sv
// sirv_uart_txarb
// Two-requester UART transmitter: round-robin arbitration between two byte
// sources, then 8N1 serialization (LSB first) at bit period io_div+1 clocks.
// Optional macro SIRV_UART_TXARB_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   io_en                 : allow new frames to be accepted
//   io_div                : baud divisor, captured at handshake
//   io_reqN_valid/bits    : requester N offers a byte
//   io_reqN_ready         : requester N's byte is taken this cycle
//   io_txd                : serial line, idle high
//   io_busy               : frame in progress
//   io_grant              : requester owning the current/last frame
module sirv_uart_txarb
    import sirv_uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic [DIV_W-1:0] io_div,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [7:0]       io_req0_bits,
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [7:0]       io_req1_bits,
    output logic             io_txd,
    output logic             io_busy,
    output logic             io_grant
);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [DIV_W-1:0]          div_q;
    logic [2:0]                bit_cnt_q;
    logic                      rr_q;
    logic                      grant_q;
`ifdef SIRV_UART_TXARB_PARITY_EN
    logic                      par_q;
`endif

    logic             arb_ok;
    logic             winner;
    logic             hs;
    logic [7:0]       win_bits;
    logic             tick;
    logic             baud_load;
    logic [DIV_W-1:0] baud_div;

    // Handshake: a byte transfers on a rising clock when valid and ready are
    // both high. ready is offered only in IDLE with io_en set, to one winner
    // only, and never depends on the other requester's ready. A requester may
    // drop valid before ready without effect but must hold bits while valid.
    // rr_q holds the last winner; on contention the other requester wins.
    assign arb_ok        = (state_q == ST_IDLE) && io_en && (io_req0_valid || io_req1_valid);
    assign winner        = (io_req0_valid && io_req1_valid) ? ~rr_q : io_req1_valid;
    assign io_req0_ready = arb_ok && !winner;
    assign io_req1_ready = arb_ok && winner;
    assign hs            = (io_req0_valid && io_req0_ready) || (io_req1_valid && io_req1_ready);
    assign win_bits      = winner ? io_req1_bits : io_req0_bits;

    // Load the fresh divisor at handshake so START already uses it; reload the
    // captured divisor at every bit boundary so mid-frame io_div changes are ignored.
    assign baud_load = hs || ((state_q != ST_IDLE) && tick);
    assign baud_div  = hs ? io_div : div_q;

    sirv_uart_baudtick #(
        .DIV_W (DIV_W)
    ) u_baudtick (
        .clock (clock),
        .reset (reset),
        .load  (baud_load),
        .div   (baud_div),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_cnt_q == UART_LAST_BIT)) begin
`ifdef SIRV_UART_TXARB_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef SIRV_UART_TXARB_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        io_txd  = 1'b1;
        io_busy = (state_q != ST_IDLE);
        case (state_q)
            ST_START:  io_txd = 1'b0;
            ST_DATA:   io_txd = shift_q[0];
`ifdef SIRV_UART_TXARB_PARITY_EN
            ST_PARITY: io_txd = par_q;
`endif
            default:   io_txd = 1'b1;
        endcase
    end

    // Datapath: capture on handshake, shift on each data-bit tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            rr_q      <= 1'b1;
            grant_q   <= 1'b0;
`ifdef SIRV_UART_TXARB_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (hs) begin
            shift_q   <= win_bits;
            div_q     <= io_div;
            bit_cnt_q <= '0;
            rr_q      <= winner;
            grant_q   <= winner;
`ifdef SIRV_UART_TXARB_PARITY_EN
            par_q     <= ^win_bits;
`endif
        end else if ((state_q == ST_DATA) && tick) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    assign io_grant = grant_q;

endmodule
